// File: rtl/mcs_io_pkg.sv
// Shared register map and control layout for the MCS IO timer bank.
// Offsets, CONTROL bit positions and IRQ register addresses live here.
package mcs_io_pkg;

    localparam logic [3:0] OFF_PRELOAD = 4'h0;
    localparam logic [3:0] OFF_COUNTER = 4'h4;
    localparam logic [3:0] OFF_CONTROL = 4'h8;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_RELOAD_BIT = 1;
    localparam int CTRL_PSC_LSB    = 8;
    localparam int CTRL_PSC_MSB    = 15;

    localparam logic [7:0] ADDR_IRQ_STATUS = 8'h80;
    localparam logic [7:0] ADDR_IRQ_ENABLE = 8'h84;

    typedef struct packed {
        logic [7:0] prescale;
        logic       reload;
        logic       en;
    } pit_ctrl_t;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/mcs_pit_channel.sv
// One timer channel: optional prescaler, down counter, expiry pulse.
// Prescaler present only with MCS_PIT_PRESCALER_EN defined.
module mcs_pit_channel
    import mcs_io_pkg::*;
#(
    parameter int C_PIT_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pit_en,
    input  logic                  preload_we,
    input  logic [C_PIT_SIZE-1:0] preload_wdata,
    input  logic                  ctrl_we,
    input  pit_ctrl_t             ctrl_wdata,
    output logic [C_PIT_SIZE-1:0] preload,
    output logic [C_PIT_SIZE-1:0] counter,
    output pit_ctrl_t             ctrl,
    output logic                  expire,
    output logic                  irq_pulse,
    output logic                  toggle
);

    logic tick;
    logic en_rise;
    logic active;

`ifdef MCS_PIT_PRESCALER_EN
    logic [7:0] psc_cnt;

    // prescale counter, restarted whenever EN rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt <= '0;
        end else if (en_rise) begin
            psc_cnt <= '0;
        end else if (ctrl.en) begin
            psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
        end
    end

    assign tick = (psc_cnt == ctrl.prescale);
`else
    assign tick = 1'b1;
`endif

    assign en_rise = ctrl_we & ctrl_wdata.en & ~ctrl.en;
    assign active  = ctrl.en & pit_en & tick;
    assign expire  = active & (counter == '0);

    // preload only takes effect at the next load or reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preload <= '0;
        end else if (preload_we) begin
            preload <= preload_wdata;
        end
    end

    // software write wins; one-shot expiry drops EN otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= '0;
        end else if (ctrl_we) begin
            ctrl <= ctrl_wdata;
        end else if (expire && !ctrl.reload) begin
            ctrl.en <= 1'b0;
        end
    end

    // down counter: load on EN rise, reload or hold at zero on expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
        end else if (en_rise) begin
            counter <= preload;
        end else if (expire) begin
            if (ctrl.reload) begin
                counter <= preload;
            end
        end else if (active) begin
            counter <= counter - 1'b1;
        end
    end

    // registered expiry pulse and toggle output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_pulse <= 1'b0;
            toggle    <= 1'b0;
        end else begin
            irq_pulse <= expire;
            toggle    <= toggle ^ expire;
        end
    end

endmodule

// File: rtl/mcs_pit_bank.sv
// MCS IO bus timer bank: bus decode, IRQ status/enable, channel array.
// Optional per-channel prescaler enabled by MCS_PIT_PRESCALER_EN.
module mcs_pit_bank
    import mcs_io_pkg::*;
#(
    parameter int C_NUM_PIT  = 4,
    parameter int C_PIT_SIZE = 32
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 IO_Addr_Strobe,
    input  logic                 IO_Read_Strobe,
    input  logic                 IO_Write_Strobe,
    input  logic [31:0]          IO_Address,
    input  logic [3:0]           IO_Byte_Enable,
    input  logic [31:0]          IO_Write_Data,
    output logic [31:0]          IO_Read_Data,
    output logic                 IO_Ready,
    input  logic [C_NUM_PIT-1:0] PIT_Enable,
    output logic [C_NUM_PIT-1:0] PIT_Interrupt,
    output logic [C_NUM_PIT-1:0] PIT_Toggle,
    output logic                 INTC_IRQ
);

    logic [7:0]  addr;
    logic [2:0]  ch_sel;
    logic [3:0]  offs;
    logic        rd;
    logic        wr;
    logic        ch_hit;
    logic [31:0] be_m;
    logic [31:0] rdata;
    logic        unused_bits;

    logic [C_NUM_PIT-1:0] irq_status;
    logic [C_NUM_PIT-1:0] irq_enable;
    logic [C_NUM_PIT-1:0] expire;
    logic [C_NUM_PIT-1:0] w1c;

    logic [C_PIT_SIZE-1:0] ch_preload [C_NUM_PIT];
    logic [C_PIT_SIZE-1:0] ch_counter [C_NUM_PIT];
    pit_ctrl_t             ch_ctrl    [C_NUM_PIT];

    assign addr   = IO_Address[7:0];
    assign ch_sel = addr[6:4];
    assign offs   = addr[3:0];
    assign rd     = IO_Addr_Strobe & IO_Read_Strobe;
    assign wr     = IO_Addr_Strobe & IO_Write_Strobe;
    assign ch_hit = ~addr[7] & (int'(ch_sel) < C_NUM_PIT);
    assign be_m   = be_mask(IO_Byte_Enable);

    assign unused_bits = ^{IO_Address[31:8], be_m, IO_Write_Data};

    for (genvar n = 0; n < C_NUM_PIT; n++) begin : g_ch
        logic                  sel;
        logic                  pl_we;
        logic                  cr_we;
        logic [C_PIT_SIZE-1:0] pl_wd;
        logic [15:0]           cr_cur;
        logic [15:0]           cr_m;
        logic [7:0]            cr_psc;
        pit_ctrl_t             cr_wd;
        logic                  unused_cr;

        assign sel   = wr & ch_hit & (ch_sel == 3'(n));
        assign pl_we = sel & (offs == OFF_PRELOAD);
        assign cr_we = sel & (offs == OFF_CONTROL);

        assign pl_wd = (ch_preload[n] & ~be_m[C_PIT_SIZE-1:0])
                     | (IO_Write_Data[C_PIT_SIZE-1:0]
                        & be_m[C_PIT_SIZE-1:0]);

        assign cr_cur = {ch_ctrl[n].prescale, 6'b0,
                         ch_ctrl[n].reload, ch_ctrl[n].en};
        assign cr_m   = (cr_cur & ~be_m[15:0])
                      | (IO_Write_Data[15:0] & be_m[15:0]);

`ifdef MCS_PIT_PRESCALER_EN
        assign cr_psc = cr_m[CTRL_PSC_MSB:CTRL_PSC_LSB];
`else
        assign cr_psc = 8'd0;
`endif

        assign cr_wd = {cr_psc, cr_m[CTRL_RELOAD_BIT], cr_m[CTRL_EN_BIT]};
        assign unused_cr = ^cr_m;

        mcs_pit_channel #(
            .C_PIT_SIZE(C_PIT_SIZE)
        ) u_ch (
            .clk          (Clk),
            .rst_n        (Reset_n),
            .pit_en       (PIT_Enable[n]),
            .preload_we   (pl_we),
            .preload_wdata(pl_wd),
            .ctrl_we      (cr_we),
            .ctrl_wdata   (cr_wd),
            .preload      (ch_preload[n]),
            .counter      (ch_counter[n]),
            .ctrl         (ch_ctrl[n]),
            .expire       (expire[n]),
            .irq_pulse    (PIT_Interrupt[n]),
            .toggle       (PIT_Toggle[n])
        );
    end

    // read mux; unmapped addresses fall through to zero
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            ch_hit: begin
                for (int n = 0; n < C_NUM_PIT; n++) begin
                    if (ch_sel == 3'(n)) begin
                        case (offs)
                            OFF_PRELOAD: rdata[C_PIT_SIZE-1:0] = ch_preload[n];
                            OFF_COUNTER: rdata[C_PIT_SIZE-1:0] = ch_counter[n];
                            OFF_CONTROL: rdata[15:0] = {ch_ctrl[n].prescale, 6'b0,
                                                        ch_ctrl[n].reload,
                                                        ch_ctrl[n].en};
                            default: ;
                        endcase
                    end
                end
            end
            (addr == ADDR_IRQ_STATUS): rdata[C_NUM_PIT-1:0] = irq_status;
            (addr == ADDR_IRQ_ENABLE): rdata[C_NUM_PIT-1:0] = irq_enable;
            default: ;
        endcase
    end

    assign w1c = (wr && addr == ADDR_IRQ_STATUS)
               ? (IO_Write_Data[C_NUM_PIT-1:0] & be_m[C_NUM_PIT-1:0])
               : '0;

    // status: expiry sets, W1C clears, expiry wins a tie
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~w1c) | expire;
        end
    end

    // byte-lane writable interrupt enable mask
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            irq_enable <= '0;
        end else if (wr && addr == ADDR_IRQ_ENABLE) begin
            irq_enable <= (irq_enable & ~be_m[C_NUM_PIT-1:0])
                        | (IO_Write_Data[C_NUM_PIT-1:0]
                           & be_m[C_NUM_PIT-1:0]);
        end
    end

    // every qualified strobe completes one cycle later
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            IO_Ready     <= 1'b0;
            IO_Read_Data <= '0;
        end else begin
            IO_Ready     <= IO_Addr_Strobe & (IO_Read_Strobe | IO_Write_Strobe);
            IO_Read_Data <= rd ? rdata : 32'd0;
        end
    end

    assign INTC_IRQ = |(irq_status & irq_enable);

endmodule
